// File: rtl/regfile_write_port.sv
// Purpose: write side of the register file; stages one write request, decodes it to one-hot enables and commits it into the bank.
// Latency: a write accepted at edge N is committed at the first edge after N with hold_i low; with REGFILE_WRITE_BYPASS_EN defined, regs_o shows staged data immediately.
// Backpressure: wr_ready_o = !pend_valid | !hold_i; a full stage under hold blocks new requests. The ZERO_REG register is never written.
module regfile_write_port #(
   parameter int DATA_WIDTH = 64,
   parameter int NUM_REGS   = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int ZERO_REG   = 31
) (
   input  logic                                 clk_i,
   input  logic                                 reset_n_i,
   input  logic                                 wr_valid_i,
   output logic                                 wr_ready_o,
   input  logic [ADDR_WIDTH-1:0]                wr_addr_i,
   input  logic [DATA_WIDTH-1:0]                wr_data_i,
   input  logic                                 hold_i,
   output logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_o,
   output logic                                 pend_valid_o,
   output logic [ADDR_WIDTH-1:0]                pend_addr_o
);

   localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(ZERO_REG);

   // Stage register holding the one write that is waiting to commit.
   logic                   pend_valid_q, pend_valid_d;
   logic [ADDR_WIDTH-1:0]  pend_addr_q,  pend_addr_d;
   logic [DATA_WIDTH-1:0]  pend_data_q,  pend_data_d;

   // Register bank storage and the decoder enables that update it.
   logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
   logic [NUM_REGS-1:0]                 dec_en;

   logic accept;
   logic commit;

   // The stage can take a new request when it is empty or is draining on this edge.
   assign wr_ready_o   = !pend_valid_q || !hold_i;
   assign accept       = wr_valid_i && wr_ready_o;
   assign commit       = pend_valid_q && !hold_i;
   assign pend_valid_o = pend_valid_q;
   assign pend_addr_o  = pend_addr_q;

   // Stage next state: a new request overwrites a committing one; otherwise a commit empties the stage.
   always_comb begin
      pend_valid_d = pend_valid_q;
      pend_addr_d  = pend_addr_q;
      pend_data_d  = pend_data_q;
      if (accept) begin
         pend_valid_d = 1'b1;
         pend_addr_d  = wr_addr_i;
         pend_data_d  = wr_data_i;
      end else if (commit) begin
         pend_valid_d = 1'b0;
         pend_addr_d  = '0;
         pend_data_d  = '0;
      end
   end

   // Stage flops; reset drops any in-flight write.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         pend_valid_q <= 1'b0;
         pend_addr_q  <= '0;
         pend_data_q  <= '0;
      end else begin
         pend_valid_q <= pend_valid_d;
         pend_addr_q  <= pend_addr_d;
         pend_data_q  <= pend_data_d;
      end
   end

   // One-hot address decode; the zero register never gets an enable.
   always_comb begin
      dec_en = '0;
      if (commit && (pend_addr_q != ZERO_ADDR)) begin
         dec_en[pend_addr_q] = 1'b1;
      end
   end

   // Bank next state: only the enabled register takes the staged data.
   always_comb begin
      regs_d = regs_q;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (dec_en[i]) begin
            regs_d[i] = pend_data_q;
         end
      end
   end

   // Bank flops.
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         regs_q <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

`ifdef REGFILE_WRITE_BYPASS_EN
   // Readers see the staged value for its destination before it reaches storage.
   always_comb begin
      regs_o = regs_q;
      if (pend_valid_q && (pend_addr_q != ZERO_ADDR)) begin
         regs_o[pend_addr_q] = pend_data_q;
      end
   end
`else
   // Readers see storage only; staged data stays hidden until it commits.
   always_comb begin
      regs_o = regs_q;
   end
`endif

endmodule

// File: tb/tb_regfile_write_port.sv
module tb_regfile_write_port;

   localparam int DW = 64;
   localparam int NR = 32;
   localparam int AW = 5;
`ifdef REGFILE_WRITE_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic                    clk = 1'b0;
   logic                    reset_n;
   logic                    wr_valid;
   logic                    wr_ready;
   logic [AW-1:0]           wr_addr;
   logic [DW-1:0]           wr_data;
   logic                    hold;
   logic [NR-1:0][DW-1:0]   regs;
   logic                    pend_valid;
   logic [AW-1:0]           pend_addr;

   logic [NR-1:0][DW-1:0]   exp_regs;
   logic [DW-1:0]           ones;
   logic [DW-1:0]           exp_val;
   int                      pass_cnt = 0;
   int                      total_cnt = 0;

   regfile_write_port dut (
      .clk_i        (clk),
      .reset_n_i    (reset_n),
      .wr_valid_i   (wr_valid),
      .wr_ready_o   (wr_ready),
      .wr_addr_i    (wr_addr),
      .wr_data_i    (wr_data),
      .hold_i       (hold),
      .regs_o       (regs),
      .pend_valid_o (pend_valid),
      .pend_addr_o  (pend_addr)
   );

   always #5 clk = ~clk;

   // Advance past the next rising edge; inputs are then driven away from the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; hold = 1'b0;
      exp_regs = '0;
      step(); step();
      reset_n = 1'b1;
      #1;
      total_cnt++;
      if (regs !== exp_regs) $display("FAIL reset_regs got=%h exp=0", regs); else pass_cnt++;
      total_cnt++;
      if (pend_valid !== 1'b0) $display("FAIL reset_pend_valid got=%b exp=0", pend_valid); else pass_cnt++;
      total_cnt++;
      if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); else pass_cnt++;
      // Write X5 = all ones and let it commit.
      wr_valid = 1'b1; wr_addr = 5'd5; wr_data = ones;
      step();
      wr_valid = 1'b0;
      step();
      #1;
      total_cnt++;
      if (regs[5] !== ones) $display("FAIL reset_pre_x5 got=%h exp=%h", regs[5], ones); else pass_cnt++;
      // Stage X6 then reset asynchronously mid-cycle while it is pending.
      wr_valid = 1'b1; wr_addr = 5'd6; wr_data = 64'h6666;
      step();
      wr_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      total_cnt++;
      if (regs !== exp_regs) $display("FAIL reset_async_regs got=%h exp=0", regs); else pass_cnt++;
      total_cnt++;
      if (pend_valid !== 1'b0) $display("FAIL reset_async_pend got=%b exp=0", pend_valid); else pass_cnt++;
      total_cnt++;
      if (pend_addr !== 5'd0) $display("FAIL reset_async_paddr got=%0d exp=0", pend_addr); else pass_cnt++;
      step();
      reset_n = 1'b1;
      step();
      #1;
      total_cnt++;
      if (wr_ready !== 1'b1) $display("FAIL reset_release_ready got=%b exp=1", wr_ready); else pass_cnt++;
      total_cnt++;
      if (regs[6] !== 64'd0) $display("FAIL reset_dropped_x6 got=%h exp=0", regs[6]); else pass_cnt++;
   endtask

   task automatic test_basic_write();
      wr_valid = 1'b1; wr_addr = 5'd0; wr_data = ones;
      step();                           // edge N: X0 accepted
      wr_addr = 5'd2;
      #1;
      total_cnt++;
      if (pend_valid !== 1'b1 || pend_addr !== 5'd0)
         $display("FAIL basic_stage0 got=%b/%0d exp=1/0", pend_valid, pend_addr); else pass_cnt++;
      step();                           // edge N+1: X0 commits, X2 accepted
      wr_valid = 1'b0;
      #1;
      total_cnt++;
      if (regs[0] !== ones) $display("FAIL basic_x0 got=%h exp=%h", regs[0], ones); else pass_cnt++;
      exp_val = BYP ? ones : 64'd0;
      total_cnt++;
      if (regs[2] !== exp_val) $display("FAIL basic_x2_early got=%h exp=%h", regs[2], exp_val); else pass_cnt++;
      step();                           // edge N+2: X2 commits
      #1;
      exp_regs[0] = ones; exp_regs[2] = ones;
      total_cnt++;
      if (regs !== exp_regs) $display("FAIL basic_bank got=%h exp=%h", regs, exp_regs); else pass_cnt++;
      total_cnt++;
      if (regs[1] !== 64'd0) $display("FAIL basic_x1 got=%h exp=0", regs[1]); else pass_cnt++;
   endtask

   task automatic test_zero_reg();
      wr_valid = 1'b1; wr_addr = 5'd31; wr_data = 64'h1234;
      #1;
      total_cnt++;
      if (wr_ready !== 1'b1) $display("FAIL zero_ready got=%b exp=1", wr_ready); else pass_cnt++;
      step();
      wr_valid = 1'b0;
      #1;
      total_cnt++;
      if (pend_valid !== 1'b1 || pend_addr !== 5'd31)
         $display("FAIL zero_staged got=%b/%0d exp=1/31", pend_valid, pend_addr); else pass_cnt++;
      total_cnt++;
      if (regs[31] !== 64'd0) $display("FAIL zero_x31_staged got=%h exp=0", regs[31]); else pass_cnt++;
      step();
      #1;
      total_cnt++;
      if (pend_valid !== 1'b0) $display("FAIL zero_pulse got=%b exp=0", pend_valid); else pass_cnt++;
      total_cnt++;
      if (regs !== exp_regs) $display("FAIL zero_bank got=%h exp=%h", regs, exp_regs); else pass_cnt++;
   endtask

   task automatic test_stall();
      wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 64'hA5A5;
      step();                           // X3 staged
      hold = 1'b1; wr_addr = 5'd9; wr_data = 64'hDEAD;   // must be ignored
      exp_val = BYP ? 64'hA5A5 : 64'd0;
      for (int i = 0; i < 3; i++) begin
         #1;
         total_cnt++;
         if (wr_ready !== 1'b0) $display("FAIL stall_ready_%0d got=%b exp=0", i, wr_ready); else pass_cnt++;
         total_cnt++;
         if (regs[3] !== exp_val) $display("FAIL stall_x3_%0d got=%h exp=%h", i, regs[3], exp_val); else pass_cnt++;
         total_cnt++;
         if (pend_valid !== 1'b1 || pend_addr !== 5'd3)
            $display("FAIL stall_stage_%0d got=%b/%0d exp=1/3", i, pend_valid, pend_addr); else pass_cnt++;
         step();
      end
      hold = 1'b0; wr_valid = 1'b0;
      #1;
      total_cnt++;
      if (wr_ready !== 1'b1) $display("FAIL stall_release_ready got=%b exp=1", wr_ready); else pass_cnt++;
      step();
      #1;
      exp_regs[3] = 64'hA5A5;
      total_cnt++;
      if (regs !== exp_regs) $display("FAIL stall_bank got=%h exp=%h", regs, exp_regs); else pass_cnt++;
      // Hold with an empty stage still accepts, then waits.
      hold = 1'b1; wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 64'h77;
      #1;
      total_cnt++;
      if (wr_ready !== 1'b1) $display("FAIL holdempty_ready got=%b exp=1", wr_ready); else pass_cnt++;
      step();
      wr_valid = 1'b0;
      step();
      #1;
      exp_val = BYP ? 64'h77 : 64'd0;
      total_cnt++;
      if (pend_valid !== 1'b1 || regs[10] !== exp_val)
         $display("FAIL holdempty_wait got=%b/%h exp=1/%h", pend_valid, regs[10], exp_val); else pass_cnt++;
      hold = 1'b0;
      step();
      #1;
      exp_regs[10] = 64'h77;
      total_cnt++;
      if (regs !== exp_regs) $display("FAIL holdempty_bank got=%h exp=%h", regs, exp_regs); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 64'd1;
      step();
      wr_data = 64'd2;
      step();                           // X7=1 commits, X7=2 accepted
      wr_valid = 1'b0;
      #1;
      exp_val = BYP ? 64'd2 : 64'd1;
      total_cnt++;
      if (regs[7] !== exp_val) $display("FAIL b2b_first got=%h exp=%h", regs[7], exp_val); else pass_cnt++;
      total_cnt++;
      if (pend_valid !== 1'b1 || pend_addr !== 5'd7)
         $display("FAIL b2b_stage got=%b/%0d exp=1/7", pend_valid, pend_addr); else pass_cnt++;
      step();
      #1;
      exp_regs[7] = 64'd2;
      total_cnt++;
      if (regs !== exp_regs) $display("FAIL b2b_second got=%h exp=%h", regs, exp_regs); else pass_cnt++;
      total_cnt++;
      if (pend_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", pend_valid); else pass_cnt++;
   endtask

   task automatic test_bypass();
      hold = 1'b1; wr_valid = 1'b1; wr_addr = 5'd4; wr_data = 64'hBEEF;
      step();
      wr_valid = 1'b0;
      #1;
      exp_val = BYP ? 64'hBEEF : 64'd0;
      total_cnt++;
      if (regs[4] !== exp_val) $display("FAIL bypass_staged got=%h exp=%h", regs[4], exp_val); else pass_cnt++;
      hold = 1'b0;
      step();
      #1;
      exp_regs[4] = 64'hBEEF;
      total_cnt++;
      if (regs !== exp_regs) $display("FAIL bypass_commit got=%h exp=%h", regs, exp_regs); else pass_cnt++;
   endtask

   initial begin
      ones = '1;
      test_reset();
      test_basic_write();
      test_zero_reg();
      test_stall();
      test_back_to_back();
      test_bypass();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
